// File: rtl/pf_iod_dly_trainer_if.sv
// IOD lane / training-control signal bundle for pf_iod_dly_trainer.
// master = trainer (drives the delay line), slave = IOD lane and fabric side.
interface pf_iod_dly_trainer_if #(
   parameter int unsigned OFS_W = 8
);
   logic             TRAIN_START;
   logic             EYE_MONITOR_EARLY;
   logic             EYE_MONITOR_LATE;
   logic             DELAY_LINE_OUT_OF_RANGE;
   logic             DELAY_LINE_LOAD;
   logic             DELAY_LINE_MOVE;
   logic             DELAY_LINE_DIRECTION;
   logic             EYE_MONITOR_CLEAR_FLAGS;
   logic             TRAIN_BUSY;
   logic             TRAIN_DONE;
   logic [1:0]       TRAIN_ERR;
   logic [OFS_W-1:0] TAP_OFFSET;
   logic [7:0]       STEP_COUNT;

   modport master (
      input  TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
      output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
      output TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_OFFSET, STEP_COUNT
   );

   modport slave (
      output TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
      input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
      input  TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_OFFSET, STEP_COUNT
   );
endinterface

// File: rtl/pf_iod_dly_trainer.sv
// Per-lane IOD delay-line trainer: steps taps until early/late evidence balances, then locks.
// Define PF_IOD_DLY_TRAINER_TRACK_EN to keep re-centring the lane while locked.
module pf_iod_dly_trainer #(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned SAMPLE_CYCLES = 16,
   parameter int unsigned THRESHOLD     = 2,
   parameter int unsigned LOCK_COUNT    = 3,
   parameter int unsigned MAX_STEPS     = 127,
   parameter int unsigned OFS_W         = 8
) (
   input  logic                        FAB_CLK,
   input  logic                        ARST_N,
   pf_iod_dly_trainer_if.master        lane
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
      S_DECIDE, S_MV_SETUP, S_MV_PULSE, S_LOCKED, S_ERROR
   } state_t;

   localparam int unsigned TMR_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned CNT_W   = $clog2(SAMPLE_CYCLES + 1);
   localparam int unsigned LCK_W   = $clog2(LOCK_COUNT + 1);
   localparam logic [OFS_W-1:0] OFS_MAX = {1'b0, {(OFS_W-1){1'b1}}};
   localparam logic [OFS_W-1:0] OFS_MIN = ~OFS_MAX + OFS_W'(1);

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   early_q, early_d;
   logic [CNT_W-1:0]   late_q, late_d;
   logic [LCK_W-1:0]   lock_q, lock_d;
   logic               dir_q, dir_d;
   logic [OFS_W-1:0]   offset_q, offset_d;
   logic [7:0]         step_q, step_d;
   logic [1:0]         err_q, err_d;
   logic               trk_q, trk_d;
   logic               load_q, clr_q, move_q, busy_q, done_q;

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      early_d  = early_q;
      late_d   = late_q;
      lock_d   = lock_q;
      dir_d    = dir_q;
      offset_d = offset_q;
      step_d   = step_q;
      err_d    = err_q;
      trk_d    = trk_q;

      case (state_q)
         S_IDLE, S_ERROR, S_LOCKED: begin
            if (lane.TRAIN_START) begin
               // Run state is cleared on the way in so LOAD already shows it cleared.
               state_d  = S_LOAD;
               offset_d = '0;
               step_d   = '0;
               lock_d   = '0;
               err_d    = '0;
            end
`ifdef PF_IOD_DLY_TRAINER_TRACK_EN
            else if (state_q == S_LOCKED) begin
               state_d = S_CLEAR;
            end
`endif
         end
         S_LOAD: state_d = S_CLEAR;
         S_CLEAR: begin
            early_d = '0;
            late_d  = '0;
            tmr_d   = '0;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (lane.DELAY_LINE_OUT_OF_RANGE) begin
               err_d   = 2'b01;
               tmr_d   = '0;
               state_d = S_ERROR;
            end else if (32'(tmr_q) == SETTLE_CYCLES - 1) begin
               tmr_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_SAMPLE: begin
            if (lane.EYE_MONITOR_EARLY && 32'(early_q) < SAMPLE_CYCLES) early_d = early_q + CNT_W'(1);
            if (lane.EYE_MONITOR_LATE && 32'(late_q) < SAMPLE_CYCLES) late_d = late_q + CNT_W'(1);
            if (32'(tmr_q) == SAMPLE_CYCLES - 1) begin
               tmr_d   = '0;
               state_d = S_DECIDE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_DECIDE: begin
            if (32'(early_q) > 32'(late_q) + THRESHOLD) begin
               dir_d   = 1'b1;
               lock_d  = '0;
               state_d = S_MV_SETUP;
            end else if (32'(late_q) > 32'(early_q) + THRESHOLD) begin
               dir_d   = 1'b0;
               lock_d  = '0;
               state_d = S_MV_SETUP;
            end else if (trk_q) begin
               state_d = S_LOCKED;
            end else begin
               lock_d  = lock_q + LCK_W'(1);
               state_d = (32'(lock_q) + 1 >= LOCK_COUNT) ? S_LOCKED : S_CLEAR;
            end
         end
         S_MV_SETUP: begin
            if (!trk_q && 32'(step_q) == MAX_STEPS) begin
               err_d   = 2'b10;
               state_d = S_ERROR;
            end else if ((dir_q && offset_q == OFS_MAX) || (!dir_q && offset_q == OFS_MIN)) begin
               err_d   = 2'b01;
               state_d = S_ERROR;
            end else begin
               state_d = S_MV_PULSE;
            end
         end
         S_MV_PULSE: begin
            offset_d = dir_q ? offset_q + OFS_W'(1) : offset_q - OFS_W'(1);
            if (!trk_q) step_d = step_q + 8'd1;
            state_d = trk_q ? S_LOCKED : S_CLEAR;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_LOAD || state_d == S_ERROR) trk_d = 1'b0;
`ifdef PF_IOD_DLY_TRAINER_TRACK_EN
      if (state_d == S_LOCKED) trk_d = 1'b1;
`endif
   end

   // Outputs are registered from the next state so each pulse spans exactly its state's cycle.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         early_q  <= '0;
         late_q   <= '0;
         lock_q   <= '0;
         dir_q    <= 1'b0;
         offset_q <= '0;
         step_q   <= '0;
         err_q    <= '0;
         trk_q    <= 1'b0;
         load_q   <= 1'b0;
         clr_q    <= 1'b0;
         move_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         early_q  <= early_d;
         late_q   <= late_d;
         lock_q   <= lock_d;
         dir_q    <= dir_d;
         offset_q <= offset_d;
         step_q   <= step_d;
         err_q    <= err_d;
         trk_q    <= trk_d;
         load_q   <= (state_d == S_LOAD);
         clr_q    <= (state_d == S_CLEAR);
         move_q   <= (state_d == S_MV_PULSE);
         busy_q   <= !trk_d && !(state_d inside {S_IDLE, S_LOCKED, S_ERROR});
         done_q   <= (state_d == S_LOCKED) || trk_d;
      end
   end

   assign lane.DELAY_LINE_LOAD         = load_q;
   assign lane.DELAY_LINE_MOVE         = move_q;
   assign lane.DELAY_LINE_DIRECTION    = dir_q;
   assign lane.EYE_MONITOR_CLEAR_FLAGS = clr_q;
   assign lane.TRAIN_BUSY              = busy_q;
   assign lane.TRAIN_DONE              = done_q;
   assign lane.TRAIN_ERR               = err_q;
   assign lane.TAP_OFFSET              = offset_q;
   assign lane.STEP_COUNT              = step_q;

endmodule
